// File: rtl/os_core_sequencer.sv
// os_core_sequencer: generates the 36-bit instruction word for the
// output-stationary core, one word per cycle. Each input-channel pass loads
// weights into the IFIFO and activations into L0, then executes. After the
// last pass the array is drained to the OFIFO and the OFIFO is written to pmem.
// Optional build macro SEQ_PERF_CNT_EN adds the perf_cycles/stall_cycles counters.
module os_core_sequencer #(
    parameter int          LEN_NIJ   = 9,
    parameter int          LEN_KIJ   = 9,
    parameter int          LEN_IC    = 3,
    parameter int          LEN_ONIJ  = 8,
    parameter logic [10:0] ACT_BASE  = 11'h000,
    parameter logic [10:0] W_BASE    = 11'h400,
    parameter logic [10:0] P_BASE    = 11'h000,
    parameter int          RD_LAT    = 1,
    parameter int          EXEC_TAIL = 8,
    parameter int          GAP_CYC   = 16,
    parameter int          DRAIN_CYC = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        ofifo_valid,
    output logic [35:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  ic_idx
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [15:0] stall_cycles
`endif
);

    // mode=1, all active-low enables deasserted, everything else 0
    localparam logic [35:0] IDLE_WORD = 36'h5_800C_0000;

    localparam logic [15:0] KIJ_N      = 16'(LEN_KIJ);
    localparam logic [15:0] NIJ_N      = 16'(LEN_NIJ);
    localparam logic [15:0] LAT_N      = 16'(RD_LAT);
    localparam logic [15:0] W_LAST     = 16'(LEN_KIJ + RD_LAT - 1);
    localparam logic [15:0] A_LAST     = 16'(LEN_NIJ + RD_LAT - 1);
    localparam logic [15:0] E_LAST     = 16'(LEN_NIJ + EXEC_TAIL - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC - 1);
    localparam logic [15:0] ONIJ_LAST  = 16'(LEN_ONIJ - 1);
    localparam logic [3:0]  IC_LAST    = 4'(LEN_IC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_ALOAD, S_EXEC, S_GAP, S_DRAIN, S_OUTWR, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  ic_q, ic_d;
    logic [35:0] inst_q, inst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  icidx_q, icidx_d;

    // State, phase counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ic_q    <= '0;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            icidx_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ic_q    <= ic_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            icidx_q <= icidx_d;
        end
    end

    // Next state and the word for the current state (registered one cycle later)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ic_d    = ic_q;
        inst_d  = IDLE_WORD;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WLOAD;
                    cnt_d   = '0;
                    ic_d    = '0;
                end
            end
            S_WLOAD: begin
                busy_d = 1'b1;
                if (cnt_q < KIJ_N) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = W_BASE + cnt_q[10:0];
                end
                // read data arrives RD_LAT cycles after the address
                if (cnt_q >= LAT_N) inst_d[5] = 1'b1;
                if (cnt_q == W_LAST) begin
                    state_d = S_ALOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ALOAD: begin
                busy_d = 1'b1;
                if (cnt_q < NIJ_N) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = ACT_BASE + cnt_q[10:0];
                end
                if (cnt_q >= LAT_N) inst_d[2] = 1'b1;
                if (cnt_q == A_LAST) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_EXEC: begin
                busy_d    = 1'b1;
                inst_d[1] = 1'b1;
                // tail cycles flush the array skew with no new operands
                if (cnt_q < NIJ_N) begin
                    inst_d[3] = 1'b1;
                    inst_d[4] = 1'b1;
                end
                if (cnt_q == E_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (ic_q < IC_LAST) begin
                        ic_d    = ic_q + 4'd1;
                        state_d = S_WLOAD;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                busy_d     = 1'b1;
                inst_d[35] = 1'b1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_OUTWR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_OUTWR: begin
                busy_d = 1'b1;
                // an empty OFIFO stalls with the idle word and holds j
                if (ofifo_valid) begin
                    inst_d[6]     = 1'b1;
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = P_BASE + cnt_q[10:0];
                    if (cnt_q == ONIJ_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        icidx_d = ic_q;
        // abort overrides every transition and suppresses the done pulse
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ic_d    = '0;
            inst_d  = IDLE_WORD;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            icidx_d = '0;
        end
    end

    assign inst   = inst_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign ic_idx = icidx_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
    logic [15:0] stall_q, stall_d;

    // Saturating busy-cycle and OFIFO-stall counters, cleared by start
    always_comb begin
        perf_d  = perf_q;
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start) begin
            perf_d  = '0;
            stall_d = '0;
        end else begin
            if (busy_q && (perf_q != '1)) perf_d = perf_q + 32'd1;
            if ((state_q == S_OUTWR) && !ofifo_valid && !abort && (stall_q != '1))
                stall_d = stall_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q  <= '0;
            stall_q <= '0;
        end else begin
            perf_q  <= perf_d;
            stall_q <= stall_d;
        end
    end

    assign perf_cycles  = perf_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_os_core_sequencer.sv
// Directed, table-driven bench for os_core_sequencer (default parameters).
module tb_os_core_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        ofifo_valid;
    logic [35:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  ic_idx;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles;
    logic [15:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    os_core_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .ic_idx      (ic_idx)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles),
        .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic        ofv;
        logic [35:0] exp_inst;
        logic        exp_busy;
        logic [3:0]  exp_ic;
    } vec_t;

    localparam int NT = 54;
    vec_t tbl[NT];

    int n_chk  = 0;
    int n_pass = 0;

    // Build a word from its fields; mode=1, acc=0 always.
    // st = {ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load}
    function automatic logic [35:0] mkw(input logic oe, input logic cenp, input logic wenp,
                                        input logic [10:0] ap, input logic cenx,
                                        input logic wenx, input logic [10:0] ax,
                                        input logic [6:0] st);
        mkw = {oe, 1'b1, 1'b0, cenp, wenp, ap, cenx, wenx, ax, st};
    endfunction

    logic [35:0] IDLE_W;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Runs a complete sequence from a start pulse and checks its shape.
    task automatic run_seq(input int stall_len, input bit start_exec1, input bit use_tbl,
                           input int exp_done);
        int       done_idx, ndone, nw, wr_bad, noe, nexe, nif, nl0, stall_drv, nseq;
        logic [3:0] icseq[4];
        logic [3:0] last_ic;
        bit       pulsed, found;
        done_idx = -1; ndone = 0; nw = 0; wr_bad = 0; noe = 0; nexe = 0;
        nif = 0; nl0 = 0; stall_drv = 0; nseq = 0; last_ic = 4'hF;
        pulsed = 0; found = 0;
        for (int i = 0; i < 4; i++) icseq[i] = 4'hF;
        ofifo_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (inst !== IDLE_W) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("first_word_seen", 64'(found), 64'd1);
        if (!found) return;
        for (int idx = 0; idx < 600; idx++) begin
            if (use_tbl && idx < NT) begin
                chk($sformatf("tbl_inst[%0d]", idx), 64'(inst), 64'(tbl[idx].exp_inst));
                chk($sformatf("tbl_busy[%0d]", idx), 64'(busy), 64'(tbl[idx].exp_busy));
                chk($sformatf("tbl_ic[%0d]", idx), 64'(ic_idx), 64'(tbl[idx].exp_ic));
            end
            if (inst[35]) noe++;
            if (inst[1])  nexe++;
            if (inst[5])  nif++;
            if (inst[2])  nl0++;
            if (ic_idx !== last_ic && !done && busy) begin
                if (nseq < 4) icseq[nseq] = ic_idx;
                nseq++;
                last_ic = ic_idx;
            end
            if (inst[32] === 1'b0) begin
                if (inst[31] !== 1'b0 || inst[6] !== 1'b1 || inst[30:20] !== 11'(nw)) wr_bad++;
                nw++;
            end else if (inst[6] === 1'b1) begin
                wr_bad++;
            end
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) done_idx = idx;
            end
            if (start_exec1 && !pulsed && ic_idx == 4'd1 && inst[1]) begin
                start  = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (use_tbl && idx < NT) ofifo_valid = tbl[idx].ofv;
            else if (nw == 3 && stall_drv < stall_len) begin
                ofifo_valid = 1'b0;
                stall_drv++;
            end else ofifo_valid = 1'b1;
            if (ndone > 0 && idx >= done_idx + 4) break;
            @(negedge clk);
        end
        start = 1'b0;
        ofifo_valid = 1'b1;
        chk("done_cycle", 64'(done_idx), 64'(exp_done));
        chk("done_pulses", 64'(ndone), 64'd1);
        chk("pmem_writes", 64'(nw), 64'd8);
        chk("pmem_write_shape", 64'(wr_bad), 64'd0);
        chk("output_en_cycles", 64'(noe), 64'd32);
        chk("execute_cycles", 64'(nexe), 64'd51);
        chk("ififo_wr_cycles", 64'(nif), 64'd27);
        chk("l0_wr_cycles", 64'(nl0), 64'd27);
        chk("ic_seq_len", 64'(nseq), 64'd3);
        chk("ic_seq", 64'({icseq[0], icseq[1], icseq[2]}), 64'h012);
        if (start_exec1) chk("start_pulsed_in_exec1", 64'(pulsed), 64'd1);
        chk("idle_after_done", 64'(inst), 64'(IDLE_W));
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int n, nonidle, nd;
        logic [10:0] a;
`ifdef SEQ_PERF_CNT_EN
        logic [31:0] pc;
`endif
        IDLE_W = mkw(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0);

        // pass 0: W_LOAD (10), A_LOAD (10), EXEC (17), GAP (16), then W_LOAD of pass 1
        for (int k = 0; k < 10; k++) begin
            a = (k < 9) ? 11'(11'h400 + k) : 11'd0;
            tbl[k] = '{1'b1, mkw(1'b0, 1'b1, 1'b1, 11'd0, (k < 9) ? 1'b0 : 1'b1, 1'b1, a,
                                 (k >= 1) ? 7'b0100000 : 7'b0), 1'b1, 4'd0};
        end
        for (int k = 0; k < 10; k++) begin
            a = (k < 9) ? 11'(k) : 11'd0;
            tbl[10 + k] = '{1'b1, mkw(1'b0, 1'b1, 1'b1, 11'd0, (k < 9) ? 1'b0 : 1'b1, 1'b1, a,
                                      (k >= 1) ? 7'b0000100 : 7'b0), 1'b1, 4'd0};
        end
        for (int k = 0; k < 17; k++)
            tbl[20 + k] = '{1'b1, mkw(1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0,
                                      (k < 9) ? 7'b0011010 : 7'b0000010), 1'b1, 4'd0};
        for (int k = 0; k < 16; k++)
            tbl[37 + k] = '{1'b1, IDLE_W, 1'b1, 4'd0};
        tbl[53] = '{1'b1, mkw(1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 1'b1, 11'h400, 7'd0), 1'b1, 4'd1};

        // reset state
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; ofifo_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_inst", 64'(inst), 64'(IDLE_W));
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_ic", 64'(ic_idx), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold_inst", 64'(inst), 64'(IDLE_W));

        // full run: 3x(10+10+17+16) + 32 + 8 cycles before the done cycle
        run_seq(0, 1'b0, 1'b1, 199);
        repeat (3) @(negedge clk);

        // OFIFO empty for 5 cycles after the 3rd pmem write
        run_seq(5, 1'b0, 1'b0, 204);
        repeat (3) @(negedge clk);

        // start during EXEC of pass 1 is ignored
        run_seq(0, 1'b1, 1'b0, 199);
        repeat (3) @(negedge clk);

        // asynchronous reset mid-EXEC of pass 1
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (inst[1] && ic_idx == 4'd1) n++;
            if (n == 3) break;
        end
        chk("exec1_reached", 64'(n), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_inst", 64'(inst), 64'(IDLE_W));
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_ic", 64'(ic_idx), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_seq(0, 1'b0, 1'b0, 199);
        repeat (3) @(negedge clk);

        // abort during DRAIN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (inst[35]) n++;
            if (n == 3) break;
        end
        chk("drain_reached", 64'(n), 64'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_inst", 64'(inst), 64'(IDLE_W));
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ic", 64'(ic_idx), 64'd0);
`ifdef SEQ_PERF_CNT_EN
        pc = perf_cycles;
`endif
        nonidle = 0; nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (inst !== IDLE_W) nonidle++;
            if (done === 1'b1) nd++;
        end
        chk("abort_stays_idle", 64'(nonidle), 64'd0);
        chk("abort_no_done", 64'(nd), 64'd0);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_frozen_after_abort", 64'(perf_cycles), 64'(pc));
        chk("perf_nonzero", 64'(perf_cycles != 32'd0), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
